// File: rtl/auth_request_arbiter.sv
// auth_request_arbiter
//   Round-robin arbiter and sequencer for NUM_CH authentication requesters. A granted
//   channel's 8-bit descriptor is latched and decoded, and the responder or initiator engine
//   is started. The engine result is then presented to the sink until it is acknowledged.
//   Waits on the engine and on the sink are bounded by TIMEOUT_CYC cycles.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req_pending/req_desc   per-channel request level and descriptor {slot,role,usb,type}
//   req_erase              one-cycle one-hot clear of the granted request
//   resp_start/init_start  engine enables, held for the whole engine wait
//   eng_slot/eng_type      latched descriptor fields for the engines
//   resp_done/init_done    engine completion, eng_msg valid the same cycle
//   msg_out/msg_usb/msg_ch captured message, USB framing flag, source channel
//   msg_valid/msg_ack      result handshake with the sink
//   err_timeout/err_role   one-cycle error pulses
//   busy                   high whenever a transaction is in progress
module auth_request_arbiter #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned MSG_W       = 64,
   parameter int unsigned TIMEOUT_CYC = 1000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   req_pending,
   input  logic [8*NUM_CH-1:0] req_desc,
   output logic [NUM_CH-1:0]   req_erase,
   output logic                resp_start,
   output logic                init_start,
   output logic [1:0]          eng_slot,
   output logic [1:0]          eng_type,
   input  logic                resp_done,
   input  logic                init_done,
   input  logic [MSG_W-1:0]    eng_msg,
   output logic [MSG_W-1:0]    msg_out,
   output logic                msg_usb,
   output logic [CH_W-1:0]     msg_ch,
   output logic                msg_valid,
   input  logic                msg_ack,
   output logic                err_timeout,
   output logic                err_role,
   output logic                busy
);

   localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [1:0] RoleResp = 2'b01;
   localparam logic [1:0] RoleInit = 2'b10;

   typedef enum logic [2:0] {StIdle, StGrant, StDispatch, StWaitEng, StWaitAck} state_e;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [1:0]         slot_q, slot_d, role_q, role_d, usb_q, usb_d, type_q, type_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [NUM_CH-1:0]  erase_q, erase_d;
   logic [MSG_W-1:0]   msg_q, msg_d;
   logic               usb_flag_q, usb_flag_d;
   logic               resp_start_q, resp_start_d, init_start_q, init_start_d;
   logic               valid_q, valid_d, err_to_q, err_to_d, err_role_q, err_role_d;
   logic               busy_q, busy_d;

   logic [CH_W-1:0]    winner, cand;
   logic               found;
   logic [7:0]         win_desc;
   logic               role_ok, timer_max, eng_done;

   // First pending channel at or after rr_ptr, wrapping.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
         if (!found && req_pending[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign win_desc  = req_desc[{winner, 3'b000} +: 8];
   assign role_ok   = (role_q == RoleResp) || (role_q == RoleInit);
   assign timer_max = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
   // Only the done of the engine that was started counts.
   assign eng_done  = (role_q == RoleResp) ? resp_done : init_done;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      timer_d    = timer_q;
      slot_d     = slot_q;
      role_d     = role_q;
      usb_d      = usb_q;
      type_d     = type_q;
      ch_d       = ch_q;
      msg_d      = msg_q;
      usb_flag_d = usb_flag_q;
      erase_d    = '0;
      err_to_d   = 1'b0;
      err_role_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (found) begin
               state_d  = StGrant;
               ch_d     = winner;
               slot_d   = win_desc[7:6];
               role_d   = win_desc[5:4];
               usb_d    = win_desc[3:2];
               type_d   = win_desc[1:0];
               erase_d  = NUM_CH'(1) << winner;
               rr_ptr_d = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
            end
         end
         StGrant: begin
            state_d    = StDispatch;
            err_role_d = !role_ok;
         end
         StDispatch: begin
            if (role_ok) begin
               state_d = StWaitEng;
               timer_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StWaitEng: begin
            if (eng_done) begin
               state_d    = StWaitAck;
               timer_d    = '0;
               msg_d      = eng_msg;
               usb_flag_d = |usb_q;
            end else if (timer_max) begin
               state_d  = StIdle;
               err_to_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StWaitAck: begin
            if (msg_ack) begin
               state_d = StIdle;
            end else if (timer_max) begin
               state_d  = StIdle;
               err_to_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Level outputs follow the next state so they are registered with it.
      busy_d       = (state_d != StIdle);
      resp_start_d = (state_d == StWaitEng) && (role_d == RoleResp);
      init_start_d = (state_d == StWaitEng) && (role_d == RoleInit);
      valid_d      = (state_d == StWaitAck);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         timer_q      <= '0;
         slot_q       <= '0;
         role_q       <= '0;
         usb_q        <= '0;
         type_q       <= '0;
         ch_q         <= '0;
         msg_q        <= '0;
         usb_flag_q   <= 1'b0;
         erase_q      <= '0;
         resp_start_q <= 1'b0;
         init_start_q <= 1'b0;
         valid_q      <= 1'b0;
         err_to_q     <= 1'b0;
         err_role_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         timer_q      <= timer_d;
         slot_q       <= slot_d;
         role_q       <= role_d;
         usb_q        <= usb_d;
         type_q       <= type_d;
         ch_q         <= ch_d;
         msg_q        <= msg_d;
         usb_flag_q   <= usb_flag_d;
         erase_q      <= erase_d;
         resp_start_q <= resp_start_d;
         init_start_q <= init_start_d;
         valid_q      <= valid_d;
         err_to_q     <= err_to_d;
         err_role_q   <= err_role_d;
         busy_q       <= busy_d;
      end
   end

   assign req_erase   = erase_q;
   assign resp_start  = resp_start_q;
   assign init_start  = init_start_q;
   assign eng_slot    = slot_q;
   assign eng_type    = type_q;
   assign msg_out     = msg_q;
   assign msg_usb     = usb_flag_q;
   assign msg_ch      = ch_q;
   assign msg_valid   = valid_q;
   assign err_timeout = err_to_q;
   assign err_role    = err_role_q;
   assign busy        = busy_q;

endmodule
